// File: rtl/traffic_cmd_ctrl.sv
// Command front end for the traffic_light bus: synchronises and debounces board
// buttons/switches, then issues guarded one-cycle instruction strobes.
module traffic_cmd_ctrl #(
  parameter int                  DB_WIDTH  = 16,
  parameter logic [DB_WIDTH-1:0] DB_CYCLES = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_send,
  input  logic       btn_go,
  input  logic       btn_stop,
  input  logic [1:0] sw_sel,
  input  logic       sw_color,
  input  logic       sw_start,
  input  logic [3:0] sw_time,
  output logic       inst_send,
  output logic [1:0] traffic_sel,
  output logic       color_sel,
  output logic       start_color,
  output logic [3:0] input_time,
  output logic       is_running,
  output logic       err
);

  // state | meaning
  // CFG   | idle, accepting configuration sends and go
  // SEND  | inst_send strobe cycle, fields already stable
  // RUN   | lights running, config locked out
  typedef enum logic [1:0] {CFG, SEND, RUN} state_t;

  localparam logic [DB_WIDTH-1:0] DB_LOAD = DB_CYCLES - {{(DB_WIDTH-1){1'b0}}, 1'b1};

  state_t              state;
  logic [2:0]          btn_s1, btn_s2, btn_stable, btn_rise;
  logic [DB_WIDTH-1:0] db_cnt [3];
  logic [7:0]          sw_s1, sw_s2;
  logic [3:0]          g_zero, r_zero;

  logic       send_p, go_p, stop_p;
  logic [1:0] sel_s;
  logic       color_s, start_s;
  logic [3:0] time_s;

  assign send_p = btn_rise[0];
  assign go_p   = btn_rise[1];
  assign stop_p = btn_rise[2];
  assign {sel_s, color_s, start_s, time_s} = sw_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= {btn_stop, btn_go, btn_send};
      btn_s2 <= btn_s1;
      sw_s1  <= {sw_sel, sw_color, sw_start, sw_time};
      sw_s2  <= sw_s1;
    end
  end

  // Down-counter reloads whenever the input agrees with the stable level,
  // so any bounce restarts the full DB_CYCLES window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_stable <= '0;
      btn_rise   <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        btn_rise[i] <= 1'b0;
        if (btn_s2[i] == btn_stable[i]) begin
          db_cnt[i] <= DB_LOAD;
        end else if (db_cnt[i] == '0) begin
          btn_stable[i] <= btn_s2[i];
          btn_rise[i]   <= btn_s2[i];
          db_cnt[i]     <= DB_LOAD;
        end else begin
          db_cnt[i] <= db_cnt[i] - {{(DB_WIDTH-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= CFG;
      inst_send   <= 1'b0;
      err         <= 1'b0;
      is_running  <= 1'b0;
      traffic_sel <= '0;
      color_sel   <= 1'b0;
      start_color <= 1'b0;
      input_time  <= '0;
      g_zero      <= '0;
      r_zero      <= '0;
    end else begin
      inst_send <= 1'b0;
      err       <= 1'b0;
      case (state)
        CFG: begin
          if (stop_p) begin
            state <= CFG;
          end else if (go_p) begin
            if (|(g_zero & r_zero)) begin
              err <= 1'b1;
            end else begin
              state      <= RUN;
              is_running <= 1'b1;
            end
          end else if (send_p) begin
            traffic_sel <= sel_s;
            color_sel   <= color_s;
            start_color <= start_s;
            input_time  <= time_s;
            if (color_s) g_zero[sel_s] <= (time_s == 4'd0);
            else         r_zero[sel_s] <= (time_s == 4'd0);
            state     <= SEND;
            inst_send <= 1'b1;
          end
        end
        SEND: state <= CFG;
        RUN: begin
          if (stop_p) begin
            state      <= CFG;
            is_running <= 1'b0;
          end else if (!go_p && send_p) begin
            err <= 1'b1;
          end
        end
        default: begin
          state      <= CFG;
          is_running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_cmd_ctrl.sv
// Directed bench for traffic_cmd_ctrl with a short debounce window (DB_CYCLES = 4).
module tb_traffic_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_send = 1'b0, btn_go = 1'b0, btn_stop = 1'b0;
  logic [1:0] sw_sel = '0;
  logic       sw_color = 1'b0, sw_start = 1'b0;
  logic [3:0] sw_time = '0;
  logic       inst_send, color_sel, start_color, is_running, err;
  logic [1:0] traffic_sel;
  logic [3:0] input_time;

  always #5 clk = ~clk;

  traffic_cmd_ctrl #(.DB_WIDTH(16), .DB_CYCLES(16'd4)) dut (
    .clk(clk), .rst(rst),
    .btn_send(btn_send), .btn_go(btn_go), .btn_stop(btn_stop),
    .sw_sel(sw_sel), .sw_color(sw_color), .sw_start(sw_start), .sw_time(sw_time),
    .inst_send(inst_send), .traffic_sel(traffic_sel), .color_sel(color_sel),
    .start_color(start_color), .input_time(input_time),
    .is_running(is_running), .err(err)
  );

  int n_chk = 0, n_fail = 0;
  int cnt_inst, cnt_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic watch(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (inst_send) cnt_inst++;
      if (err) cnt_err++;
    end
  endtask

  // m = {stop, go, send}; hold long enough to be accepted, then release and settle
  task automatic press(input logic [2:0] m);
    cnt_inst = 0;
    cnt_err  = 0;
    {btn_stop, btn_go, btn_send} = m;
    watch(14);
    {btn_stop, btn_go, btn_send} = 3'b000;
    watch(10);
  endtask

  task automatic set_sw(input logic [1:0] s, input logic c, input logic st, input logic [3:0] t);
    sw_sel = s; sw_color = c; sw_start = st; sw_time = t;
    repeat (3) @(negedge clk);
  endtask

  int at_k;
  logic [7:0] fields_at;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outputs", {inst_send, traffic_sel, color_sel, start_color, input_time, is_running, err}, 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // bounce on send, then a clean hold; config fields sel=2 green start=1 time=7
    set_sw(2'd2, 1'b1, 1'b1, 4'd7);
    cnt_inst = 0;
    cnt_err  = 0;
    for (int c = 0; c < 20; c++) begin
      btn_send = ((c / 2) % 2 == 0);
      @(negedge clk);
      if (inst_send) cnt_inst++;
    end
    chk("bounce_no_send", cnt_inst, 0);
    btn_send = 1'b1;
    at_k = 0;
    fields_at = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (inst_send) begin
        cnt_inst++;
        at_k = k;
        fields_at = {traffic_sel, color_sel, start_color, input_time};
      end
      if (err) cnt_err++;
    end
    btn_send = 1'b0;
    watch(10);
    chk("bounce_send_count", cnt_inst, 1);
    chk("bounce_latency", at_k, 7);
    chk("bounce_err", cnt_err, 0);
    chk("cfg_fields_at_strobe", fields_at, {2'd2, 1'b1, 1'b1, 4'd7});
    chk("cfg_fields_hold", {traffic_sel, color_sel, start_color, input_time}, {2'd2, 1'b1, 1'b1, 4'd7});

    press(3'b100);
    chk("stop_in_cfg_err", cnt_err, 0);
    chk("stop_in_cfg_run", is_running, 0);

    // zero guard on light 1
    set_sw(2'd1, 1'b1, 1'b0, 4'd0);
    press(3'b001);
    chk("g0_send", cnt_inst, 1);
    set_sw(2'd1, 1'b0, 1'b0, 4'd0);
    press(3'b001);
    chk("r0_send", cnt_inst, 1);
    press(3'b010);
    chk("guard_err", cnt_err, 1);
    chk("guard_not_running", is_running, 0);
    set_sw(2'd1, 1'b0, 1'b0, 4'd3);
    press(3'b001);
    chk("r3_send", cnt_inst, 1);
    chk("r3_time", input_time, 4'd3);
    press(3'b010);
    chk("go_running", is_running, 1);
    chk("go_err", cnt_err, 0);
    chk("go_no_inst", cnt_inst, 0);

    // lockout while running
    set_sw(2'd3, 1'b1, 1'b1, 4'd9);
    press(3'b001);
    chk("lock_err", cnt_err, 1);
    chk("lock_no_inst", cnt_inst, 0);
    chk("lock_fields", {traffic_sel, color_sel, start_color, input_time}, {2'd1, 1'b0, 1'b0, 4'd3});
    chk("lock_running", is_running, 1);
    press(3'b100);
    chk("stop_idle", is_running, 0);
    chk("stop_err", cnt_err, 0);

    // coincident pulses
    press(3'b011);
    chk("gosend_running", is_running, 1);
    chk("gosend_inst", cnt_inst, 0);
    chk("gosend_err", cnt_err, 0);
    press(3'b101);
    chk("stopsend_idle", is_running, 0);
    chk("stopsend_err", cnt_err, 0);
    chk("stopsend_inst", cnt_inst, 0);

    // asynchronous reset while running
    press(3'b010);
    chk("pre_reset_running", is_running, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_outputs", {inst_send, input_time, traffic_sel, is_running, err}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    set_sw(2'd0, 1'b1, 1'b0, 4'd5);
    press(3'b001);
    chk("post_reset_send", cnt_inst, 1);
    chk("post_reset_send_err", cnt_err, 0);
    chk("post_reset_fields", {traffic_sel, color_sel, start_color, input_time}, {2'd0, 1'b1, 1'b0, 4'd5});
    press(3'b010);
    chk("post_reset_go", is_running, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
